// File: rtl/piso_shift_register_pkg.sv
// Shared mode encoding for the parallel-in, serial-out serialiser.
// The load/shift select is a single bit; naming it keeps the datapath readable.
package piso_shift_register_pkg;

  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_SHIFT = 1'b1
  } mode_e;

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter, MSB first with zero fill; load visible on SOut the edge it happens.
// Latency: one edge from Data_In to SOut; no backpressure, the upstream controller paces WIDTH shifts.
module piso_shift_register
  import piso_shift_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data_In,
  output logic             SOut
);

  logic [WIDTH-1:0] shreg;
  mode_e            mode;

  assign mode = mode_e'(Load);

  // A load always wins over an in-flight shift; untransmitted bits are dropped.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shreg <= '0;
    end else if (mode == MODE_LOAD) begin
      shreg <= Data_In;
    end else begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign SOut = shreg[WIDTH-1];

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register (WIDTH = 4): every expected SOut value is hand-computed.
module tb_piso_shift_register;

  logic       Clock;
  logic       Reset;
  logic       Load;
  logic [3:0] Data_In;
  logic       SOut;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_register #(.WIDTH(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (Load),
    .Data_In (Data_In),
    .SOut    (SOut)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [3:0] pat;

    Reset   = 1'b0;
    Load    = 1'b0;
    Data_In = 4'b1111;
    #1;
    check_bit("reset_t0", SOut, 1'b0);
    step();
    check_bit("reset_edge1", SOut, 1'b0);
    step();
    check_bit("reset_edge2", SOut, 1'b0);

    // Release reset away from the edge, then load 0101 and shift it out.
    Reset   = 1'b1;
    Data_In = 4'b0101;
    Load    = 1'b0;
    step();
    check_bit("w0101_load", SOut, 1'b0);
    Load = 1'b1;
    pat  = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit($sformatf("w0101_shift%0d", i + 1), SOut, pat[3 - i]);
    end
    step();
    check_bit("w0101_flush1", SOut, 1'b0);
    step();
    check_bit("w0101_flush2", SOut, 1'b0);

    // Asymmetric word: MSB first then zero fill.
    Load    = 1'b0;
    Data_In = 4'b1000;
    step();
    check_bit("w1000_load", SOut, 1'b1);
    Load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_bit($sformatf("w1000_shift%0d", i + 1), SOut, 1'b0);
    end

    // Reload in the middle of a shift sequence.
    Load    = 1'b0;
    Data_In = 4'b1100;
    step();
    check_bit("w1100_load", SOut, 1'b1);
    Load = 1'b1;
    step();
    check_bit("w1100_shift1", SOut, 1'b1);
    Load    = 1'b0;
    Data_In = 4'b0011;
    step();
    check_bit("reload_0011", SOut, 1'b0);
    Load = 1'b1;
    pat  = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit($sformatf("reload_shift%0d", i + 1), SOut, pat[3 - i]);
    end
    step();
    check_bit("reload_flush", SOut, 1'b0);

    // Continuous load: SOut follows Data_In[3] one edge late, never combinationally.
    Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Data_In = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      step();
      check_bit($sformatf("cont_load%0d", i), SOut, (i % 2 == 0) ? 1'b1 : 1'b0);
      Data_In = (i % 2 == 0) ? 4'b0000 : 4'b1000;
      #2;
      check_bit($sformatf("cont_hold%0d", i), SOut, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset in the middle of a shift.
    Data_In = 4'b1111;
    Load    = 1'b0;
    step();
    check_bit("w1111_load", SOut, 1'b1);
    Load = 1'b1;
    step();
    check_bit("w1111_shift1", SOut, 1'b1);
    step();
    check_bit("w1111_shift2", SOut, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check_bit("async_reset", SOut, 1'b0);
    step();
    check_bit("reset_held", SOut, 1'b0);
    Reset = 1'b1;
    step();
    check_bit("post_reset_shift1", SOut, 1'b0);
    step();
    check_bit("post_reset_shift2", SOut, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parameterised parallel-in, serial-out shift register. It captures a WIDTH-bit parallel word on a load cycle, then presents it one bit per clock on a single serial output, MSB first. It serves as the serialiser stage between a parallel datapath and a one-bit serial link or test output.

## Interface

Parameters:
- WIDTH, default 4, parallel word width (≥ 2).

Ports:
- Clock  input  1  rising-edge clock, the only clock.
- Reset  input  1  asynchronous, active-low reset.
- Load  input  1  mode select: 0 = parallel load, 1 = shift.
- Data_In  input  WIDTH  parallel data word, sampled only on load cycles.
- SOut  output  1  serial data out, equal to the MSB of the internal shift register.

## Operation

- Internal state is one WIDTH-bit register, shreg.
- Reset low:
  - Clears shreg to all zeros immediately, without waiting for a clock edge.
  - SOut = 0.
  - Held for as long as Reset stays low.
- Rising Clock edge with Reset high and Load = 0: shreg ← Data_In.
- Rising Clock edge with Reset high and Load = 1: shreg ← {shreg[WIDTH-2:0], 1'b0}.
  - This is a left shift with zero fill. The MSB leaves first.
- SOut = shreg[WIDTH-1] at all times.
  - SOut is a registered output with no combinational path from Data_In or Load.
- Bit order on SOut after a load of word D: D[WIDTH-1], D[WIDTH-2], …, D[0]. After that, 0s for as long as shifting continues.
- No busy/done flag. The upstream controller counts WIDTH shift cycles itself.
- Load = 0 held across several edges reloads Data_In on every edge. SOut then tracks Data_In[WIDTH-1] one cycle late.
- A load in the middle of a shift sequence discards the untransmitted bits and starts the new word on that edge. This is legal behaviour, not an error.
- Reset takes priority over Load at all times.

## Timing

- Reset assertion: SOut = 0 within the same delta cycle, independent of Clock.
- Reset deassertion: the first rising edge with Reset high acts according to Load.
  - The bench must not change Reset on the same edge it expects a load.
- Load latency: SOut shows Data_In[WIDTH-1] right after the load edge (zero extra cycles).
- Shift latency: bit D[WIDTH-1-k] appears on SOut after the k-th shift edge following the load.
  - Example: D[0] appears after shift edge WIDTH-1.
- Flush: after WIDTH shift edges, shreg = 0 and SOut = 0 until the next load.
- Setup requirement: Data_In and Load must be stable before the sampling edge. Neither is synchronised inside the block.

## Structure

- Single flat module, piso_shift_register, with one always block for async reset, load and shift, plus a continuous assign for SOut.
- No shared package is needed. WIDTH is the only constant and stays a module parameter.
- No sub-modules.
- If the codebase wants a reusable register primitive, a natural optional split is a WIDTH-bit register with async active-low clear, named dff_arst_n. This is not required.

## Test plan

- Reset: hold Reset = 0 for 2 cycles with Data_In = 4'b1111 and Load = 0 → SOut = 0 throughout. Assert Reset mid-cycle → SOut drops to 0 before the next edge.
- Load then shift 4'b0101 (WIDTH = 4): release Reset, Load = 0 for one edge, then Load = 1 → SOut sequence 0, 1, 0, 1, then 0, 0, … on successive edges.
- Asymmetric word 4'b1000: load, then shift → SOut 1, 0, 0, 0, 0, confirming MSB-first order and zero fill.
- Reload mid-shift: load 4'b1100, shift 1 edge (SOut = 1), then load 4'b0011 → SOut = 0 on the load edge, then 0, 1, 1 on the next three shift edges.
- Continuous load: Load = 0 while Data_In toggles 4'b1000 / 4'b0000 every cycle → SOut follows Data_In[3] one edge later. The shift path never runs.
- Reset mid-shift: load 4'b1111, shift 2 edges, pull Reset low asynchronously → SOut = 0 at once. Release Reset with Load = 1 → SOut stays 0.
